// File: rtl/test_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_monitor_pkg
// Description : Shared state codes, result signature and index helper for
//               the test_monitor run-control / observation block.
// Revision    : 1.0 - initial release
// ============================================================================
package test_monitor_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // Value that x26 / x27 must hold to signal "done" / "pass".
  localparam int SIG_VALUE = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of the dirty vector at or after the pointer, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import test_monitor_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] dirty,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  // Walk the channels starting at the pointer; the first dirty one wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_CH)) begin
        sum = sum - (IDX_W+1)'(NUM_CH);
      end
      cand = sum[IDX_W-1:0];
      if (!found && dirty[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : test_monitor
// Description : Core reset sequencing, run-cycle counting, done/pass
//               detection on x26/x27 and a valid/ready stream of
//               value-change records from a set of watched registers.
// Revision    : 1.0 - initial release
// ============================================================================
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 32,
  parameter  int RST_HOLD = 8,
  parameter  int STABLE   = 2,
  parameter  int TIMEOUT  = 100000,
  parameter  int CNT_W    = 32,
  localparam int CH_W     = idx_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        done_reg,
  input  logic [DATA_W-1:0]        pass_reg,
  input  logic [NUM_CH*DATA_W-1:0] watch_bus,
  input  logic                     chg_ready,
  output logic                     core_rst_n,
  output logic [2:0]               state,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic                     chg_valid,
  output logic [CH_W-1:0]          chg_ch,
  output logic [DATA_W-1:0]        chg_data,
  output logic                     test_done,
  output logic                     test_pass,
  output logic                     test_timeout
);

  localparam int                HOLD_W = $clog2(RST_HOLD + 1);
  localparam int                STB_W  = $clog2(STABLE + 1);
  localparam logic [DATA_W-1:0] SIG    = DATA_W'(SIG_VALUE);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic                chg_valid_q, chg_valid_d;
  logic [CH_W-1:0]     chg_ch_q, chg_ch_d;
  logic [DATA_W-1:0]   chg_data_q, chg_data_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   snap_q [NUM_CH];
  logic [DATA_W-1:0]   snap_d [NUM_CH];

  logic [DATA_W-1:0]   ch_val [NUM_CH];
  logic [NUM_CH-1:0]   dirty;
  logic                pick_found;
  logic [CH_W-1:0]     pick_idx;

  // A channel is dirty whenever its live value differs from the last one reported.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign ch_val[i] = watch_bus[i*DATA_W +: DATA_W];
    assign dirty[i]  = (ch_val[i] != snap_q[i]);
  end

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .dirty (dirty),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: FSM, counters, result flags and event register.
  always_comb begin
    logic out_free;
    logic complete;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_rst_n_d = core_rst_n_q;
    cycle_cnt_d  = cycle_cnt_q;
    stable_d     = stable_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    chg_valid_d  = chg_valid_q;
    chg_ch_d     = chg_ch_q;
    chg_data_d   = chg_data_q;
    ptr_d        = ptr_q;
    snap_d       = snap_q;
    out_free     = !chg_valid_q || chg_ready;
    complete     = 1'b0;

    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        // Follow the bus while the core is in reset so start-up values are silent.
        for (int i = 0; i < NUM_CH; i++) begin
          snap_d[i] = ch_val[i];
        end
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d      = ST_RUN;
          core_rst_n_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        stable_d = (done_reg == SIG) ? stable_q + 1'b1 : '0;
        complete = (done_reg == SIG) && (stable_q == STB_W'(STABLE - 1));
        // Completion takes priority over a timeout on the same edge.
        if (complete) begin
          state_d = (pass_reg == SIG) ? ST_PASS : ST_FAIL;
          done_d  = 1'b1;
          pass_d  = (pass_reg == SIG);
        end else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
        if (out_free) begin
          if (pick_found) begin
            chg_valid_d      = 1'b1;
            chg_ch_d         = pick_idx;
            chg_data_d       = ch_val[pick_idx];
            snap_d[pick_idx] = ch_val[pick_idx];
            ptr_d            = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
          end else begin
            chg_valid_d = 1'b0;
          end
        end
      end

      default: begin
        // Terminal: drain a presented event, never load a new one.
        if (chg_valid_q && chg_ready) begin
          chg_valid_d = 1'b0;
        end
      end
    endcase
  end

  // State register with synchronous active-low reset; snapshots load the live bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      core_rst_n_q <= 1'b0;
      cycle_cnt_q  <= '0;
      stable_q     <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      chg_valid_q  <= 1'b0;
      chg_ch_q     <= '0;
      chg_data_q   <= '0;
      ptr_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= ch_val[i];
      end
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stable_q     <= stable_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      chg_valid_q  <= chg_valid_d;
      chg_ch_q     <= chg_ch_d;
      chg_data_q   <= chg_data_d;
      ptr_q        <= ptr_d;
      snap_q       <= snap_d;
    end
  end

  assign core_rst_n   = core_rst_n_q;
  assign state        = state_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign chg_valid    = chg_valid_q;
  assign chg_ch       = chg_ch_q;
  assign chg_data     = chg_data_q;
  assign test_done    = done_q;
  assign test_pass    = pass_q;
  assign test_timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/test_monitor.md
# test_monitor

Synthesizable run-control and observation block for simulating and emulating the RISC-V SoC. It sequences the core's reset release and counts run cycles. It detects the test-completion convention: x26 is the done flag, x27 is the pass flag. It streams value-change events from a parametrised set of watched registers through a valid/ready port, replacing per-cycle register printing with compact, ordered change records.

## Interface
- `NUM_CH`, 4: number of watched channels (1..16).
- `DATA_W`, 32: width of each watched value and of `done_reg` / `pass_reg`.
- `RST_HOLD`, 8: cycles the core is held in reset after `rst` deasserts (≥1).
- `STABLE`, 2: consecutive cycles `done_reg==1` must hold to count as completion (≥1).
- `TIMEOUT`, 100000: run-cycle limit before timeout (≥2).
- `CNT_W`, 32: width of `cycle_cnt`.

Ports:
- `clk`: in, 1 bit. Single clock.
- `rst`: in, 1 bit. Reset is synchronous and active-low.
- `done_reg`: in, `DATA_W`. Core x26.
- `pass_reg`: in, `DATA_W`. Core x27.
- `watch_bus`: in, `NUM_CH*DATA_W`. Channel i occupies bits [i*DATA_W +: DATA_W].
- `chg_ready`: in, 1 bit. Consumer accepts the current event.
- `core_rst_n`: out, 1 bit. Active-low reset to the core. Registered.
- `state`: out, 3 bits. Current FSM state code.
- `cycle_cnt`: out, `CNT_W`. Number of RUN cycles elapsed; saturates at all-ones.
- `chg_valid`: out, 1 bit. A change event is presented.
- `chg_ch`: out, `$clog2(NUM_CH)` bits (minimum 1). Index of the channel that changed.
- `chg_data`: out, `DATA_W`. New value of the channel.
- `test_done`, `test_pass`, `test_timeout`: out, 1 bit each. Sticky result flags.

## Operation
- **States:** HOLD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4. PASS, FAIL and TIMEOUT are terminal; only `rst` leaves them.
- **Reset (`rst==0` at a clock edge):**
  - state=HOLD, hold counter=0, `core_rst_n`=0, `cycle_cnt`=0.
  - `chg_valid`=0, `chg_ch`=0, `chg_data`=0, round-robin pointer=0.
  - All three result flags = 0, stable counter = 0.
  - Snapshots are loaded with the current `watch_bus`.
  - Reset applied mid-run aborts everything identically, including any pending event.
- **HOLD:**
  - The hold counter increments each cycle.
  - On the edge where the counter equals `RST_HOLD-1`: state becomes RUN and `core_rst_n` becomes 1.
  - Snapshots keep tracking `watch_bus`, so reset-time values never generate events.
- **RUN:**
  - `cycle_cnt` increments each cycle and saturates.
  - The stable counter increments while `done_reg==1` and clears to 0 otherwise.
  - When the stable counter reaches `STABLE`, the block completes:
    - `pass_reg==1`: state becomes PASS, `test_done`=1, `test_pass`=1.
    - Otherwise: state becomes FAIL, `test_done`=1, `test_pass`=0.
  - Timeout fires on the edge where `cycle_cnt==TIMEOUT-1` and completion does not fire: state becomes TIMEOUT, `test_timeout`=1, `test_done`=1.
  - If completion and timeout fire on the same edge, completion wins.
- **Change events (loading allowed in RUN only):**
  - Channel i is dirty when `watch_bus[i] != snap[i]`.
  - The output register is free when `chg_valid==0`, or when `chg_valid && chg_ready`.
  - When the register is free, pick the first dirty channel at or after the round-robin pointer, wrapping around.
  - On a pick: `chg_valid`=1, `chg_ch`=i, `chg_data`=`watch_bus[i]`, `snap[i]`=`watch_bus[i]`, pointer = i+1 mod `NUM_CH`.
  - Acceptance with no dirty channel clears `chg_valid`.
  - Multiple changes to one channel between picks coalesce into a single event carrying the latest value.
  - While `chg_valid && !chg_ready`, the outputs hold stable.
  - In terminal states, an already-presented event stays until accepted, then `chg_valid`=0. No new loads occur.

## Timing
- `core_rst_n` rises at the `RST_HOLD`-th rising edge with `rst` sampled high.
- All outputs are registered. Result flags and `state` update on the same edge as the transition.
- Completion latency:
  - With `done_reg` first 1 at RUN cycle k and held, `test_done` is visible after edge k+`STABLE`-1.
  - A 1-cycle glitch with `STABLE`=2 is ignored.
- Change-event latency: a value changing before edge e is presented after edge e, as long as the output register is free and the channel wins arbitration.
- Throughput: one event per cycle while `chg_ready` stays high.
- Fairness: a persistently dirty channel waits at most `NUM_CH` accepted events.

## Structure
- **Shared package `test_monitor_pkg`:**
  - State codes (HOLD..TIMEOUT) and the state width.
  - Done/pass signature constant (1).
- **Sub-module `rr_pick`:**
  - Parametrised by `NUM_CH`.
  - Inputs: dirty vector and pointer. Outputs: `found` and index.
  - Purely combinational.
- The top level holds the FSM, counters, snapshot array and event register.

## Test plan
- **Reset release:** `RST_HOLD`=8, `rst` low for 3 edges then high → `core_rst_n` 0 through edge 7, 1 after edge 8; `state` goes 0→1; `cycle_cnt` increments from 0.
- **Pass:** `STABLE`=2. In RUN, `pass_reg`=1, then `done_reg`=1 held → `state`=2, `test_done`=1, `test_pass`=1 two edges after `done_reg` rises. A 1-cycle `done_reg` pulse beforehand produces no completion.
- **Fail and timeout:**
  - Fail: `done_reg`=1, `pass_reg`=5 → `state`=3, `test_pass`=0.
  - Timeout: `TIMEOUT`=20 with no done → `state`=4, `test_timeout`=1, `cycle_cnt`=20 (edge 20 of RUN).
  - Completion on the timeout edge → PASS or FAIL, with `test_timeout`=0.
- **Change stream:** `NUM_CH`=4, `chg_ready`=1. Channels 1 and 3 change on the same cycle to 7 and 9 → events (1,7) then (3,9) on consecutive cycles. Channel 1 changing 7→8→9 during a 3-cycle back-pressure yields one event (1,9).
- **Fairness under back-pressure:** all four channels kept dirty, `chg_ready` toggling → event channel order 0,1,2,3,0… with no channel skipped; outputs stable while `chg_ready`=0.
- **Reset mid-run:** `rst` low during RUN with `chg_valid`=1 → next edge `chg_valid`=0, flags 0, `state`=0, `core_rst_n`=0; the re-run completes normally.
